hash_wb_initiator: RTL and testbench
====================================

HASH_WB_INITIATOR -- requirements
Module: hash_wb_initiator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the hash accelerator Wishbone slave.
REQ-002 SHALL have parameter POLL_LIMIT, default 1024, maximum STATUS reads per poll phase before timeout.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, request carries a 512-bit block.
REQ-006 SHALL have port cmd_ready, output, 1, initiator accepts the request.
REQ-007 SHALL have port cmd_block, input, 512, message block; word k = cmd_block[511-32k -: 32].
REQ-008 SHALL have port cmd_init, input, 1: 1 = first block (CTRL.init), 0 = continuation (CTRL.next).
REQ-009 SHALL have port rsp_valid, output, 1, response available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-011 SHALL have port rsp_digest, output, 256, digest; word k at [255-32k -: 32].
REQ-012 SHALL have port rsp_error, output, 1, bus error or poll timeout.
REQ-013 SHALL have Wishbone master ports wbm_adr_o (out, 32), wbm_dat_o (out, 32), wbm_sel_o (out, 4), wbm_we_o (out, 1), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_dat_i (in, 32), wbm_ack_i (in, 1) and wbm_err_i (in, 1).

Function
REQ-014 SHALL use this slave map: CTRL BASE+0x00 (bit0 init, bit1 next); STATUS BASE+0x04 (bit0 ready, bit1 digest_valid); BLOCK k at BASE+0x40+4k for k=0..15; DIGEST k at BASE+0x80+4k for k=0..7.
REQ-015 SHALL implement states IDLE, POLL_RDY, WR_BLOCK, WR_CTRL, POLL_DONE, RD_DIGEST and RESP.
REQ-016 SHALL drive cmd_ready=1 only in IDLE, and SHALL latch cmd_block and cmd_init on cmd_valid&&cmd_ready, then go to POLL_RDY.
REQ-017 SHALL run each bus access as a classic single transfer: cyc=stb=1 with constant adr/dat/we, sel=4'hF, held until ack or err.
REQ-018 SHALL drop cyc and stb for exactly one cycle after each ack before the next access.
REQ-019 In POLL_RDY, SHALL read STATUS until bit0=1, then go to WR_BLOCK.
REQ-020 In WR_BLOCK, SHALL write BLOCK words 0..15 in ascending order using a 4-bit counter, then go to WR_CTRL.
REQ-021 In WR_CTRL, SHALL write 32'h1 if the latched cmd_init=1, else 32'h2, then go to POLL_DONE.
REQ-022 In POLL_DONE, SHALL read STATUS until bit1=1, then go to RD_DIGEST.
REQ-023 In RD_DIGEST, SHALL read DIGEST words 0..7 in ascending order into the digest register, then go to RESP.
REQ-024 SHALL clear the poll counter on entry to each poll phase and increment it per STATUS ack.
REQ-025 When POLL_LIMIT STATUS reads complete without the awaited bit, SHALL go to RESP with rsp_error=1.
REQ-026 SHALL treat wbm_err_i=1 on any access as terminating that access, abort the sequence, and go to RESP with rsp_error=1.
REQ-027 SHALL zero rsp_digest whenever rsp_error=1.
REQ-028 In RESP, SHALL hold rsp_valid=1 with rsp_digest and rsp_error stable until rsp_ready=1, then return to IDLE; rsp_ready may be high before rsp_valid.
REQ-029 SHALL ignore wbm_ack_i and wbm_err_i when wbm_stb_o=0.
REQ-030 If ack and err are asserted together, SHALL treat the access as err.
REQ-031 SHALL keep cyc=stb=0 in IDLE and RESP.

Reset
REQ-032 Asserting rst SHALL immediately force state IDLE, all counters to 0, and all outputs to 0 (digest 0, rsp_error 0, wbm_adr_o 0).
REQ-033 Asserting rst mid-transfer SHALL drop cyc/stb at once, SHALL issue no response for the aborted command, and after release SHALL allow the first new command to be accepted on the following cycle.

Verification
REQ-034 SHALL be tested with a first "abc" block 0x61626380_0..0_00000018 against a SHA-256 slave model: expect 16 writes, CTRL=1, rsp_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, rsp_error=0.
REQ-035 SHALL be tested with the slave asserting err on BLOCK word 5: expect no CTRL write, rsp_error=1, rsp_digest=0.
REQ-036 SHALL be tested with STATUS.digest_valid never set and POLL_LIMIT=4: expect exactly 4 POLL_DONE reads, then rsp_error=1.
REQ-037 SHALL be tested with cmd_init=0: expect CTRL write data 32'h2.
REQ-038 SHALL be tested with rsp_ready held low for 10 cycles: expect rsp_valid and the data stable, cmd_ready=0 throughout, and IDLE one cycle after the handshake.
REQ-039 SHALL be tested with rst asserted during WR_BLOCK word 9: expect cyc=0 immediately, no response, and a following clean command to complete correctly.

Source files
------------

// File: rtl/hash_wb_initiator.sv
// Wishbone classic-cycle initiator that feeds one 512-bit block to a memory-mapped
// SHA-256 style accelerator, polls it, and returns the 256-bit digest (or an error).
module hash_wb_initiator #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [511:0] cmd_block,
  input  logic         cmd_init,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_digest,
  output logic         rsp_error,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  output logic [3:0]   wbm_sel_o,
  output logic         wbm_we_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] POLL_RDY  = 3'd1;
  localparam logic [2:0] WR_BLOCK  = 3'd2;
  localparam logic [2:0] WR_CTRL   = 3'd3;
  localparam logic [2:0] POLL_DONE = 3'd4;
  localparam logic [2:0] RD_DIGEST = 3'd5;
  localparam logic [2:0] RESP      = 3'd6;

  logic [2:0]    state;
  logic [511:0]  blk;
  logic          init_l;
  logic [3:0]    cnt;
  logic [PW-1:0] poll_cnt;
  logic [255:0]  digest;
  logic          err_r;
  logic          gap;

  logic          bus_state;
  logic          active;
  logic          done_ok;
  logic          done_err;
  logic          poll_last;
  logic [31:0]   blk_word;

  always_comb begin
    bus_state = state inside {POLL_RDY, WR_BLOCK, WR_CTRL, POLL_DONE, RD_DIGEST};
    // the gap cycle after every ack keeps cyc/stb low and masks ack/err
    active    = bus_state && !gap;
    done_err  = active && wbm_err_i;
    done_ok   = active && wbm_ack_i && !wbm_err_i;
    poll_last = (poll_cnt == PW'(POLL_LIMIT - 1));
  end

  always_comb begin
    blk_word = '0;
    for (int unsigned k = 0; k < 16; k++)
      if (cnt == 4'(k)) blk_word = blk[511-32*k -: 32];
  end

  always_comb begin
    wbm_cyc_o = active;
    wbm_stb_o = active;
    wbm_sel_o = active ? 4'hF : 4'h0;
    wbm_we_o  = active && (state == WR_BLOCK || state == WR_CTRL);
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (active) begin
      case (state)
        POLL_RDY, POLL_DONE: wbm_adr_o = BASE_ADDR + 32'h04;
        WR_BLOCK: begin
          wbm_adr_o = BASE_ADDR + 32'h40 + {26'b0, cnt, 2'b00};
          wbm_dat_o = blk_word;
        end
        WR_CTRL: begin
          wbm_adr_o = BASE_ADDR;
          wbm_dat_o = init_l ? 32'h1 : 32'h2;
        end
        RD_DIGEST: wbm_adr_o = BASE_ADDR + 32'h80 + {27'b0, cnt[2:0], 2'b00};
        default: wbm_adr_o = '0;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = (state == IDLE) && !rst;
    rsp_valid  = (state == RESP);
    rsp_error  = err_r;
    rsp_digest = err_r ? '0 : digest;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      blk      <= '0;
      init_l   <= 1'b0;
      cnt      <= '0;
      poll_cnt <= '0;
      digest   <= '0;
      err_r    <= 1'b0;
      gap      <= 1'b0;
    end else begin
      if (gap) gap <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            blk      <= cmd_block;
            init_l   <= cmd_init;
            cnt      <= '0;
            poll_cnt <= '0;
            digest   <= '0;
            err_r    <= 1'b0;
            state    <= POLL_RDY;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: begin
          if (done_err) begin
            err_r  <= 1'b1;
            digest <= '0;
            state  <= RESP;
          end else if (done_ok) begin
            gap <= 1'b1;
            case (state)
              POLL_RDY, POLL_DONE: begin
                if ((state == POLL_RDY) ? wbm_dat_i[0] : wbm_dat_i[1]) begin
                  cnt   <= '0;
                  state <= (state == POLL_RDY) ? WR_BLOCK : RD_DIGEST;
                end else if (poll_last) begin
                  err_r  <= 1'b1;
                  digest <= '0;
                  state  <= RESP;
                end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                end
              end
              WR_BLOCK: begin
                cnt <= cnt + 1'b1;
                if (cnt == 4'd15) state <= WR_CTRL;
              end
              WR_CTRL: begin
                poll_cnt <= '0;
                state    <= POLL_DONE;
              end
              RD_DIGEST: begin
                for (int unsigned k = 0; k < 8; k++)
                  if (cnt[2:0] == 3'(k)) digest[255-32*k -: 32] <= wbm_dat_i;
                cnt <= cnt + 1'b1;
                if (cnt == 4'd7) state <= RESP;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_wb_initiator.sv
// Bench for hash_wb_initiator: SHA-256 Wishbone slave model, reference model and
// response scoreboard with randomized blocks, delays and fault injection.
module tb_hash_wb_initiator;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int PL = 4;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [511:0] cmd_block = '0;
  logic         cmd_init = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [255:0] rsp_digest;
  logic         rsp_error;
  logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]   wbm_sel_o;
  logic         wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic         wbm_ack_i = 1'b0, wbm_err_i = 1'b0;

  hash_wb_initiator #(.BASE_ADDR(BASE), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_block(cmd_block), .cmd_init(cmd_init),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest), .rsp_error(rsp_error),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  typedef struct {
    logic [255:0] digest;
    logic         err;
    int           nwr;
    int           nctrl;
    logic [31:0]  ctrl;
    int           npd;
    int           nrdy;
  } exp_t;
  exp_t q[$];

  // slave configuration, set by the stimulus while the initiator is idle
  int rdy_delay = 0, dv_delay = 0, err_word = -1;
  bit never_valid = 0, never_ready = 0;

  // slave state and per-command observations
  logic [31:0]  sm_blk [16];
  logic [255:0] sh = IV;
  bit           busy = 0;
  int           wait_c = 0;
  logic [31:0]  acc_adr = '0;
  int           nwr = 0, nctrl = 0, npd = 0, nrdy = 0, pviol = 0;
  logic [31:0]  ctrl_data = '0;

  task automatic clr_stats();
    nwr = 0; nctrl = 0; npd = 0; nrdy = 0; pviol = 0; ctrl_data = '0;
  endtask

  task automatic do_access();
    logic [31:0]  off;
    logic [511:0] bb;
    int           k;
    off = wbm_adr_o - BASE;
    wbm_dat_i = $urandom;
    if (wbm_we_o) begin
      if (off == 32'h0) begin
        nctrl++;
        ctrl_data = wbm_dat_o;
        for (int i = 0; i < 16; i++) bb[511-32*i -: 32] = sm_blk[i];
        if (wbm_dat_o == 32'h1) sh = sha(IV, bb);
        else if (wbm_dat_o == 32'h2) sh = sha(sh, bb);
        wbm_ack_i = 1'b1;
      end else if (off >= 32'h40 && off < 32'h80) begin
        k = int'((off - 32'h40) >> 2);
        if (k == err_word) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = 1'($urandom_range(0, 1));
        end else begin
          sm_blk[k] = wbm_dat_o;
          nwr++;
          wbm_ack_i = 1'b1;
        end
      end else begin
        pviol++;
        wbm_ack_i = 1'b1;
      end
    end else begin
      if (off == 32'h4) begin
        if (nctrl == 0) begin
          nrdy++;
          wbm_dat_i = {30'b0, 1'b0, (nrdy > rdy_delay) && !never_ready};
        end else begin
          npd++;
          wbm_dat_i = {30'b0, (npd > dv_delay) && !never_valid, 1'b1};
        end
      end else if (off >= 32'h80 && off < 32'ha0) begin
        k = int'((off - 32'h80) >> 2);
        wbm_dat_i = sh[255-32*k -: 32];
      end else begin
        pviol++;
      end
      wbm_ack_i = 1'b1;
    end
  endtask

  // bus slave and response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; busy = 0;
      clr_stats();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response: actual=response required=none");
        end else begin
          e = q.pop_front();
          chk("digest", rsp_digest, e.digest);
          chk("rsp_error", 256'(rsp_error), 256'(e.err));
          chk("block_writes", 256'(nwr), 256'(e.nwr));
          chk("ctrl_writes", 256'(nctrl), 256'(e.nctrl));
          if (e.nctrl > 0) chk("ctrl_data", 256'(ctrl_data), 256'(e.ctrl));
          chk("poll_done_reads", 256'(npd), 256'(e.npd));
          chk("poll_rdy_reads", 256'(nrdy), 256'(e.nrdy));
          chk("bus_protocol", 256'(pviol), 256'(0));
        end
        clr_stats();
      end
      if (wbm_ack_i || wbm_err_i) begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; busy = 0;
        if (wbm_cyc_o || wbm_stb_o) pviol++;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (!busy) begin
          busy = 1; wait_c = int'($urandom_range(0, 2)); acc_adr = wbm_adr_o;
        end else if (wbm_adr_o !== acc_adr) pviol++;
        if (wbm_sel_o !== 4'hF) pviol++;
        if (wait_c > 0) wait_c--;
        else do_access();
      end
    end
  end

  // 0: random backpressure, 1: held low, 2: held high
  int rr_mode = 0;
  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
    else rsp_ready = (rr_mode == 2);
  end

  logic [255:0] ref_h = IV;

  task automatic send(input logic [511:0] b, input logic init, input int ew,
                      input bit nv, input bit nr, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 256'(cmd_ready), 256'(1));
      return;
    end
    err_word = ew; never_valid = nv; never_ready = nr;
    rdy_delay = int'($urandom_range(0, 2)); dv_delay = int'($urandom_range(0, 2));
    cmd_block = b; cmd_init = init; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (push) begin
      e.nrdy = nr ? PL : rdy_delay + 1;
      e.ctrl = init ? 32'h1 : 32'h2;
      e.nctrl = 0; e.npd = 0; e.err = 1'b1; e.digest = '0;
      if (nr) e.nwr = 0;
      else if (ew >= 0) e.nwr = ew;
      else begin
        e.nwr = 16; e.nctrl = 1;
        ref_h = sha(init ? IV : ref_h, b);
        e.npd = nv ? PL : dv_delay + 1;
        e.err = nv;
        e.digest = nv ? '0 : ref_h;
      end
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", 256'(q.size()), 256'(0));
  endtask

  function automatic logic [511:0] rnd_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [511:0] abc;
    exp_t est;
    int n;
    #2 rst = 1'b1;
    #2;
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_error", 256'(rsp_error), 256'(0));
    chk("rst_digest", rsp_digest, '0);
    chk("rst_cyc_stb", 256'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 256'(0));
    chk("rst_adr", 256'(wbm_adr_o), 256'(0));
    chk("rst_sel_dat", 256'({wbm_sel_o, wbm_dat_o}), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0] = 32'h00000018;
    send(abc, 1'b1, -1, 0, 0, 1);
    q[q.size()-1].digest = ABC_DIGEST;
    ref_h = ABC_DIGEST;
    send(rnd_block(), 1'b0, -1, 0, 0, 1);
    send(rnd_block(), 1'b1, 5, 0, 0, 1);
    send(rnd_block(), 1'b0, -1, 1, 0, 1);
    send(rnd_block(), 1'b1, -1, 0, 1, 1);
    drain();

    rr_mode = 1;
    send(rnd_block(), 1'b1, -1, 0, 0, 1);
    est = q[q.size()-1];
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 256'(rsp_valid), 256'(1));
      chk("stall_digest", rsp_digest, est.digest);
      chk("stall_cmd_ready", 256'(cmd_ready), 256'(0));
    end
    rr_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_handshake", 256'({cmd_ready, rsp_valid}), 256'(2'b10));
    rr_mode = 0;
    drain();

    send(rnd_block(), 1'b1, -1, 0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(wbm_stb_o && wbm_adr_o == BASE + 32'h64) && n < 3000);
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc_stb", 256'({wbm_cyc_o, wbm_stb_o}), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_release", 256'(cmd_ready), 256'(1));
    send(rnd_block(), 1'b1, -1, 0, 0, 1);
    drain();

    for (int i = 0; i < 20; i++) begin
      send(rnd_block(), 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
